// File: rtl/hilo_pkg.sv
// Shared function codes and FSM state encoding for the HI/LO register block.
package hilo_pkg;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_register_if.sv
// Controller/multiplier-facing bus of hilo_register.
// dataIn exists only when HILO_MTHILO_EN is defined.
interface hilo_register_if #(
    parameter int WIDTH = 32
);
    logic [5:0]         Signal;
    logic [2*WIDTH-1:0] mulIn;
`ifdef HILO_MTHILO_EN
    logic [WIDTH-1:0]   dataIn;
`endif
    logic [WIDTH-1:0]   dataOut;
    logic               busy;
    logic               done;

`ifdef HILO_MTHILO_EN
    modport master (output Signal, mulIn, dataIn, input dataOut, busy, done);
    modport slave  (input Signal, mulIn, dataIn, output dataOut, busy, done);
`else
    modport master (output Signal, mulIn, input dataOut, busy, done);
    modport slave  (input Signal, mulIn, output dataOut, busy, done);
`endif

endinterface

// File: rtl/hilo_register_mul_iter_counter.sv
// Saturating iteration counter; terminal is high when the next increment
// reaches the limit, so the FSM can leave RUN on that same edge.
module mul_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, limit};

endmodule

// File: rtl/hilo_register.sv
// HI/LO product capture, MFHI/MFLO read port and multiply stall tracking.
// Optional MTHI/MTLO writes are enabled by defining HILO_MTHILO_EN.
module hilo_register
    import hilo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    hilo_register_if.slave bus
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_multu;
    logic             start;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_term;

    assign is_multu = (bus.Signal == MULTU);
    assign start    = (state_q == IDLE) && is_multu && armed_q;

    mul_iter_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .enable   (cnt_en),
        .clear    (cnt_clr),
        .limit    (CNT_W'(MUL_CYCLES)),
        .terminal (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dout_d  = dout_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;

        // Re-arm on any non-MULTU code so a held MULTU cannot restart.
        armed_d = armed_q;
        if (!is_multu) begin
            armed_d = 1'b1;
        end else if (start) begin
            armed_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_en  = 1'b1;
                end else begin
                    case (bus.Signal)
                        MFHI: dout_d = hi_q;
                        MFLO: dout_d = lo_q;
`ifdef HILO_MTHILO_EN
                        MTHI: hi_d = bus.dataIn;
                        MTLO: lo_d = bus.dataIn;
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_multu) begin
                    cnt_en = 1'b1;
                    if (cnt_term) begin
                        state_d = LATCH;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            LATCH: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
                hi_d    = bus.mulIn[2*WIDTH-1:WIDTH];
                lo_d    = bus.mulIn[WIDTH-1:0];
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == LATCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dataOut = dout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_hilo_register.sv
// Randomized transaction-level bench for hilo_register: expected busy/done/
// dataOut per edge are derived from hold length and the edge-numbering rules.
module tb_hilo_register;
    import hilo_pkg::*;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;
    localparam logic [5:0] NOP = 6'b000000;

    logic clk;
    logic reset;

    hilo_register_if #(.WIDTH(WIDTH)) bus ();

    hilo_register #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural HI, LO and the read register.
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] dout_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One multiply attempt: MULTU held for hold edges, then post code.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int hold, input logic [5:0] post);
        logic [63:0] prod;
        bit          cap;
        int          last_busy;
        int          svc;
        int          total;
        logic [31:0] nhi;
        logic [31:0] nlo;
        logic [31:0] rd;
        prod      = {32'b0, a} * {32'b0, b};
        cap       = (hold >= MUL_CYCLES);
        last_busy = cap ? MUL_CYCLES : hold;
        svc       = cap ? ((hold + 1 > MUL_CYCLES + 2) ? hold + 1 : MUL_CYCLES + 2) : hold + 2;
        total     = cap ? ((hold > MUL_CYCLES + 1 ? hold : MUL_CYCLES + 1) + 2) : hold + 2;
        nhi       = cap ? prod[63:32] : hi_m;
        nlo       = cap ? prod[31:0]  : lo_m;
        rd        = (post == MFHI) ? nhi : (post == MFLO) ? nlo : dout_m;
        for (int k = 1; k <= total; k++) begin
            bus.Signal = (k <= hold) ? MULTU : post;
            bus.mulIn  = (k == MUL_CYCLES + 1) ? prod : {$urandom, $urandom};
            @(posedge clk);
            #1;
            check_eq("busy", 64'(bus.busy), 64'(k <= last_busy));
            check_eq("done", 64'(bus.done), 64'(cap && (k == MUL_CYCLES + 1)));
            check_eq("dataOut", 64'(bus.dataOut), 64'((k >= svc) ? rd : dout_m));
        end
        hi_m   = nhi;
        lo_m   = nlo;
        dout_m = rd;
        $display("mul a=%h b=%h hold=%0d post=%b captured=%0d hi=%h lo=%h dout=%h",
                 a, b, hold, post, cap, hi_m, lo_m, dout_m);
    endtask

    task automatic do_read(input logic [5:0] code);
        bus.Signal = code;
        @(posedge clk);
        #1;
        if (code == MFHI) dout_m = hi_m;
        if (code == MFLO) dout_m = lo_m;
        check_eq("read", 64'(bus.dataOut), 64'(dout_m));
        check_eq("read_busy", 64'(bus.busy), 64'd0);
        $display("read code=%b dout=%h", code, bus.dataOut);
    endtask

    task automatic do_write(input logic [5:0] code, input logic [31:0] val);
        bus.Signal = code;
`ifdef HILO_MTHILO_EN
        bus.dataIn = val;
        if (code == MTHI) hi_m = val;
        if (code == MTLO) lo_m = val;
`endif
        @(posedge clk);
        #1;
        check_eq("write_dout", 64'(bus.dataOut), 64'(dout_m));
        $display("write code=%b val=%h", code, val);
    endtask

    task automatic reset_mid_mul(input int cycles);
        for (int k = 1; k <= cycles; k++) begin
            bus.Signal = MULTU;
            bus.mulIn  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check_eq("rst_busy_pre", 64'(bus.busy), 64'd1);
        end
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_dout", 64'(bus.dataOut), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        bus.Signal = NOP;
        @(posedge clk);
        #1;
        reset = 1'b1;
        hi_m   = '0;
        lo_m   = '0;
        dout_m = '0;
        $display("reset after %0d multiply cycles", cycles);
    endtask

    initial begin
        logic [5:0] posts [3];
        int         hold;
        posts[0] = MFHI;
        posts[1] = MFLO;
        posts[2] = NOP;

        reset      = 1'b0;
        bus.Signal = NOP;
        bus.mulIn  = '0;
`ifdef HILO_MTHILO_EN
        bus.dataIn = '0;
`endif
        hi_m   = '0;
        lo_m   = '0;
        dout_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dout", 64'(bus.dataOut), 64'd0);
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Largest operands, then reads of both halves.
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, MFHI);
        check_eq("max_hi", 64'(bus.dataOut), 64'h0000_0000_FFFF_FFFE);
        do_read(MFLO);
        check_eq("max_lo", 64'(bus.dataOut), 64'h0000_0000_0000_0001);

        // Read issued during LATCH completes in the first IDLE cycle.
        run_mul(32'd3, 32'd5, 32, MFLO);
        check_eq("small_lo", 64'(bus.dataOut), 64'h0000_000F);
        do_read(MFHI);

        // Abort after 10 cycles, then MULTU held past completion, then re-issue.
        run_mul($urandom, $urandom, 10, MFLO);
        run_mul($urandom, $urandom, 40, NOP);
        run_mul($urandom, $urandom, 32, MFHI);

        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 3) == 0) hold = 31 + $urandom_range(0, 2);
            else hold = $urandom_range(1, 45);
            run_mul($urandom, $urandom, hold, posts[$urandom_range(0, 2)]);
        end

        // Async reset in the middle of a multiply clears everything.
        do_read(MFHI);
        reset_mid_mul(20);
        do_read(MFHI);
        do_read(MFLO);

        // MTHI is a write with the option enabled and a no-op otherwise.
        do_write(MTHI, 32'h1234_5678);
        do_read(MFHI);
        do_write(MTLO, 32'h9ABC_DEF0);
        do_read(MFLO);
        run_mul(32'd7, 32'd9, 32, MFLO);
        do_read(MFHI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
